btn_debounce_sync: RTL and testbench

//   Input stage of the PAL datapath. Sits directly upstream of the product-term AND/OR arrays.

---
 rtl/btn_debounce_sync.sv | 81 ++++++++
 tb/tb_btn_debounce_sync.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_sync.sv
// btn_debounce_sync: synchronizes and debounces push-button inputs.
// Produces clean levels, edge pulses and a true/complement literal bus.
module btn_debounce_sync #(
    parameter int              SIZE         = 4,
    parameter int              CNT_WIDTH    = 16,
    parameter int              STABLE_COUNT = 50000,
    parameter logic [SIZE-1:0] RESET_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIZE-1:0]   btn_raw,
    output logic [SIZE-1:0]   btn_clean,
    output logic [SIZE-1:0]   btn_rise,
    output logic [SIZE-1:0]   btn_fall,
    output logic [2*SIZE-1:0] btn_lits
);

    localparam logic [CNT_WIDTH-1:0] LAST =
        CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [SIZE-1:0]      sync1;
    logic [SIZE-1:0]      sync2;
    logic [CNT_WIDTH-1:0] cnt     [SIZE];
    logic [CNT_WIDTH-1:0] cnt_nxt [SIZE];
    logic [SIZE-1:0]      clean_nxt;
    logic [SIZE-1:0]      rise_nxt;
    logic [SIZE-1:0]      fall_nxt;

    // Two-flop synchronizer; only sync2 is consumed downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Per-bit stability count; any agreeing sample restarts it.
    always_comb begin
        clean_nxt = btn_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < SIZE; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != btn_clean[i]) begin
                if (cnt[i] == LAST) begin
                    clean_nxt[i] = sync2[i];
                    rise_nxt[i]  = sync2[i];
                    fall_nxt[i]  = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + ONE;
                end
            end
        end
    end

    // Debounce state and registered edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_clean <= RESET_VAL;
            btn_rise  <= '0;
            btn_fall  <= '0;
            for (int i = 0; i < SIZE; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_clean <= clean_nxt;
            btn_rise  <= rise_nxt;
            btn_fall  <= fall_nxt;
            for (int i = 0; i < SIZE; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign btn_lits = {~btn_clean, btn_clean};

endmodule

// File: tb/tb_btn_debounce_sync.sv
// tb_btn_debounce_sync: directed table plus hand-written sequences.
// Expected values are computed by hand from the debounce timing.
module tb_btn_debounce_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_clean;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;
    logic [7:0] btn_lits;

    int errors = 0;
    int checks = 0;

    btn_debounce_sync #(
        .SIZE(4),
        .CNT_WIDTH(3),
        .STABLE_COUNT(4),
        .RESET_VAL(4'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_clean(btn_clean),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall),
        .btn_lits(btn_lits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] raw;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [7:0] lits;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] raw,
                                input logic [3:0] c, input logic [3:0] ri,
                                input logic [3:0] fa, input logic [7:0] li);
        vec_t v;
        v.rst_n = r;
        v.raw   = raw;
        v.clean = c;
        v.rise  = ri;
        v.fall  = fa;
        v.lits  = li;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        int         rises;
        logic [3:0] ec;
        logic [3:0] er;

        rst_n   = 1'b0;
        btn_raw = 4'hF;

        // reset, then first released edge, then settle to zero
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 8'hF0);
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 8'hF0);
        add(1, 4'hF, 4'h0, 4'h0, 4'h0, 8'hF0);
        repeat (3) add(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'hF0);
        // clean press of bit 0
        repeat (5) add(1, 4'h1, 4'h0, 4'h0, 4'h0, 8'hF0);
        add(1, 4'h1, 4'h1, 4'h1, 4'h0, 8'hE1);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0, 8'hE1);
        // release of bit 0
        repeat (5) add(1, 4'h0, 4'h1, 4'h0, 4'h0, 8'hE1);
        add(1, 4'h0, 4'h0, 4'h0, 4'h1, 8'hF0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'hF0);
        // simultaneous press of bits 3 and 1
        repeat (5) add(1, 4'hA, 4'h0, 4'h0, 4'h0, 8'hF0);
        add(1, 4'hA, 4'hA, 4'hA, 4'h0, 8'h5A);
        add(1, 4'hA, 4'hA, 4'h0, 4'h0, 8'h5A);
        // bit 0 toggling every cycle never accepts
        for (int t = 0; t < 20; t++)
            add(1, (t % 2 == 0) ? 4'hB : 4'hA, 4'hA, 4'h0, 4'h0, 8'h5A);
        repeat (3) add(1, 4'hA, 4'hA, 4'h0, 4'h0, 8'h5A);
        // simultaneous release
        repeat (5) add(1, 4'h0, 4'hA, 4'h0, 4'h0, 8'h5A);
        add(1, 4'h0, 4'h0, 4'h0, 4'hA, 8'hF0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'hF0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n   = vecs[i].rst_n;
            btn_raw = vecs[i].raw;
            tick();
            chk($sformatf("vec%0d_clean", i), {4'h0, btn_clean},
                {4'h0, vecs[i].clean});
            chk($sformatf("vec%0d_rise", i), {4'h0, btn_rise},
                {4'h0, vecs[i].rise});
            chk($sformatf("vec%0d_fall", i), {4'h0, btn_fall},
                {4'h0, vecs[i].fall});
            chk($sformatf("vec%0d_lits", i), btn_lits, vecs[i].lits);
        end

        // bounce on bit 1: raw 1,1,1,0,1,1,1,1 then held
        pat   = 8'b1111_0111;
        rises = 0;
        for (int j = 0; j < 12; j++) begin
            btn_raw = {2'b00, (j < 8) ? pat[j] : 1'b1, 1'b0};
            tick();
            if (btn_rise[1]) rises++;
            ec = (j >= 9) ? 4'h2 : 4'h0;
            er = (j == 9) ? 4'h2 : 4'h0;
            chk($sformatf("bounce%0d_clean", j), {4'h0, btn_clean},
                {4'h0, ec});
            chk($sformatf("bounce%0d_rise", j), {4'h0, btn_rise},
                {4'h0, er});
            chk($sformatf("bounce%0d_fall", j), {4'h0, btn_fall}, 8'h00);
        end
        chk("bounce_rise_count", 8'(rises), 8'd1);

        btn_raw = 4'h0;
        repeat (7) tick();
        chk("bounce_release_clean", {4'h0, btn_clean}, 8'h00);

        // reset while cnt[2]==2 discards the partial count
        btn_raw = 4'h4;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("midrst%0d_clean", j), {4'h0, btn_clean}, 8'h00);
        end
        rst_n = 1'b0;
        tick();
        chk("midrst4_clean", {4'h0, btn_clean}, 8'h00);
        chk("midrst4_rise", {4'h0, btn_rise}, 8'h00);
        rst_n = 1'b1;
        for (int j = 5; j < 12; j++) begin
            tick();
            ec = (j >= 10) ? 4'h4 : 4'h0;
            er = (j == 10) ? 4'h4 : 4'h0;
            chk($sformatf("midrst%0d_clean", j), {4'h0, btn_clean},
                {4'h0, ec});
            chk($sformatf("midrst%0d_rise", j), {4'h0, btn_rise},
                {4'h0, er});
            chk($sformatf("midrst%0d_fall", j), {4'h0, btn_fall}, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
